clken_gen: RTL and testbench

Lock-aware system reset sequencer and multi-channel fractional clock-enable generator. It sits directly behind the MMCM clock helper in the 100 MHz domain. It turns the raw MMCM `locked` into a debounced, synchronous-release `sys_rst_n`, and produces `NUM_CH` runtime-programmable tick strobes (UART oversample, timers, etc.) from phase accumulators. Successor to fixed divide-by-N clocking: arbitrary rates, per-channel gating, automatic recovery on lock loss.

---
 rtl/clken_pkg.sv | 13 +
 rtl/clken_accum.sv | 49 ++++
 rtl/clken_gen.sv | 141 ++++++++++++++
 tb/tb_clken_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// clken_gen shared definitions: FSM state encoding, loss counter width
// and the default increment reset value (~1.8432 MHz at 100 MHz).
package clken_pkg;

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_STABLE    = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;

   localparam int LOSS_CNT_W = 8;

   localparam logic [31:0] INC_INIT_DEF = 32'd79_164_837;

endpackage

// File: rtl/clken_accum.sv
// One tick channel: increment register, phase accumulator, tick flop.
// Ports: i_clk/i_rst_n, i_we/i_wdata write, i_run_cur/i_run_nxt
// (state is RUN now / after this edge), i_en gate, o_tick strobe.
module clken_accum #(
   parameter int              ACC_W   = 32,
   parameter logic [ACC_W-1:0] INC_RST = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic [ACC_W-1:0] i_wdata,
   input  logic             i_run_cur,
   input  logic             i_run_nxt,
   input  logic             i_en,
   output logic             o_tick
);

   logic [ACC_W-1:0] r_inc;
   logic [ACC_W-1:0] r_acc;
   logic             r_tick;
   logic [ACC_W:0]   w_sum;

   assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
   assign o_tick = r_tick;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inc  <= INC_RST;
         r_acc  <= '0;
         r_tick <= 1'b0;
      end else begin
         if (i_we) begin
            r_inc <= i_wdata;
         end
         // A write restarts the phase and beats a coincident overflow;
         // leaving RUN clears on the same edge the state changes.
         if (i_we || !i_run_nxt) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
         end else if (i_run_cur && i_en) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_tick <= w_sum[ACC_W];
         end else begin
            r_tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clken_gen.sv
// Lock-aware reset sequencer plus NUM_CH fractional clock-enable ticks.
// Ports: clk_100mhz, rst_n, locked_in, inc_we/inc_sel/inc_wdata, ch_en,
// tick, sys_rst_n, clk_ok, loss_cnt (only with CLKEN_LOSS_CNT_EN).
module clken_gen
   import clken_pkg::*;
#(
   parameter int          NUM_CH     = 4,
   parameter int          ACC_W      = 32,
   parameter int          STABLE_CYC = 1024,
   parameter logic [31:0] INC_INIT   = INC_INIT_DEF,
   localparam int         SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_100mhz,
   input  logic              rst_n,
   input  logic              locked_in,
   input  logic              inc_we,
   input  logic [SEL_W-1:0]  inc_sel,
   input  logic [ACC_W-1:0]  inc_wdata,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] tick,
   output logic              sys_rst_n,
   output logic              clk_ok
`ifdef CLKEN_LOSS_CNT_EN
   ,
   output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

   localparam int             CNT_W    = $clog2(STABLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [ACC_W-1:0] INC_RST  = INC_INIT[ACC_W-1:0];

   logic             r_sync1;
   logic             r_sync2;
   logic             w_lock_s;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_sys_rst_n;
   logic             w_run_cur;
   logic             w_run_nxt;

   assign w_lock_s = r_sync2;

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= locked_in;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_WAIT_LOCK: begin
            if (w_lock_s) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end
         end
         ST_STABLE: begin
            // Any drop sends us back; WAIT_LOCK re-zeroes the count.
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end
         end
         default: begin
            w_state_nxt = ST_WAIT_LOCK;
         end
      endcase
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_WAIT_LOCK;
         r_cnt       <= '0;
         r_sys_rst_n <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sys_rst_n <= (w_state_nxt == ST_RUN);
      end
   end

   assign sys_rst_n = r_sys_rst_n;
   assign clk_ok    = r_sys_rst_n;

   assign w_run_cur = (r_state == ST_RUN);
   assign w_run_nxt = (w_state_nxt == ST_RUN);

`ifdef CLKEN_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] r_loss;

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_loss <= '0;
      end else if (w_run_cur && (w_state_nxt == ST_WAIT_LOCK)
                   && (r_loss != '1)) begin
         r_loss <= r_loss + LOSS_CNT_W'(1);
      end
   end

   assign loss_cnt = r_loss;
`endif

   // Out-of-range inc_sel matches no channel, so it is dropped.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_we;

      assign w_we = inc_we && (inc_sel == SEL_W'(gi));

      clken_accum #(
         .ACC_W   (ACC_W),
         .INC_RST (INC_RST)
      ) u_accum (
         .i_clk     (clk_100mhz),
         .i_rst_n   (rst_n),
         .i_we      (w_we),
         .i_wdata   (inc_wdata),
         .i_run_cur (w_run_cur),
         .i_run_nxt (w_run_nxt),
         .i_en      (ch_en[gi]),
         .o_tick    (tick[gi])
      );
   end

endmodule

// File: tb/tb_clken_gen.sv
// Randomized bench for clken_gen against a lock-run-length model.
// Optional loss counter checks follow CLKEN_LOSS_CNT_EN.
module tb_clken_gen;

   localparam int NCH  = 3;
   localparam int AW   = 8;
   localparam int STAB = 8;
   localparam int MOD  = 1 << AW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           locked_in = 1'b0;
   logic           inc_we = 1'b0;
   logic [1:0]     inc_sel = '0;
   logic [AW-1:0]  inc_wdata = '0;
   logic [NCH-1:0] ch_en = '0;
   logic [NCH-1:0] tick;
   logic           sys_rst_n;
   logic           clk_ok;
`ifdef CLKEN_LOSS_CNT_EN
   logic [7:0]     loss_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   clken_gen #(
      .NUM_CH     (NCH),
      .ACC_W      (AW),
      .STABLE_CYC (STAB)
   ) dut (
      .clk_100mhz (clk),
      .rst_n      (rst_n),
      .locked_in  (locked_in),
      .inc_we     (inc_we),
      .inc_sel    (inc_sel),
      .inc_wdata  (inc_wdata),
      .ch_en      (ch_en),
      .tick       (tick),
      .sys_rst_n  (sys_rst_n),
      .clk_ok     (clk_ok)
`ifdef CLKEN_LOSS_CNT_EN
      ,
      .loss_cnt   (loss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model: RUN means the synced lock has been high on at least
   // STAB+1 consecutive edges.
   int           m_len = 0;
   int           m_loss = 0;
   bit           m_run = 1'b0;
   bit           s1 = 1'b0;
   bit           s2 = 1'b0;
   int           m_acc[NCH] = '{default: 0};
   int           m_inc[NCH] = '{default: 79164837 % 256};
   bit [NCH-1:0] m_tick = '0;

   always @(posedge clk or negedge rst_n) begin
      bit prev;
      int sum;
      if (!rst_n) begin
         m_len = 0;
         m_loss = 0;
         m_run = 1'b0;
         s1 = 1'b0;
         s2 = 1'b0;
         m_tick = '0;
         for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0;
            m_inc[c] = 79164837 % 256;
         end
      end else begin
         prev = m_run;
         if (s2) begin
            if (m_len < 100000) m_len = m_len + 1;
         end else begin
            m_len = 0;
         end
         m_run = (m_len >= STAB + 1);
         if (prev && !m_run && m_loss < 255) m_loss = m_loss + 1;
         s2 = s1;
         s1 = locked_in;
         for (int c = 0; c < NCH; c++) begin
            if (inc_we && int'(inc_sel) == c) begin
               m_inc[c] = int'(inc_wdata);
               m_acc[c] = 0;
               m_tick[c] = 1'b0;
            end else if (!m_run) begin
               m_acc[c] = 0;
               m_tick[c] = 1'b0;
            end else if (prev && ch_en[c]) begin
               sum = m_acc[c] + m_inc[c];
               m_tick[c] = (sum >= MOD);
               m_acc[c] = sum % MOD;
            end else begin
               m_tick[c] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      vectors++;
      if (tick !== m_tick || sys_rst_n !== m_run || clk_ok !== m_run
`ifdef CLKEN_LOSS_CNT_EN
          || int'(loss_cnt) != m_loss || ^loss_cnt === 1'bx
`endif
         ) begin
         miscompares++;
         $display("FAIL model t=%0t tick=%b exp=%b rst=%b ok=%b exp=%b",
                  $time, tick, m_tick, sys_rst_n, clk_ok, m_run);
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic wr(input int sel, input int val);
      inc_we = 1'b1;
      inc_sel = 2'(sel);
      inc_wdata = AW'(val);
      @(negedge clk);
      inc_we = 1'b0;
   endtask

   task automatic wait_rel(output int n);
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (sys_rst_n === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic wait_fall(output int n);
      n = -1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (sys_rst_n === 1'b0) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic loss_event(input bit check);
      int n;
      locked_in = 1'b0;
      wait_fall(n);
      if (check) begin
         chk("fall_edge", n, 3);
         chk("fall_tick", int'(tick), 0);
      end
      locked_in = 1'b1;
      wait_rel(n);
      if (check) chk("relock_edge", n, 11);
   endtask

   initial begin
      int n;
      int nt;
      int r;
      repeat (3) @(negedge clk);
      chk("rst_sys", int'(sys_rst_n), 0);
      chk("rst_tick", int'(tick), 0);
      rst_n = 1'b1;
      @(negedge clk);
      wr(0, 128);
      wr(1, 3);
      ch_en = 3'b011;
      repeat (3) @(negedge clk);

      locked_in = 1'b1;
      wait_rel(n);
      chk("lockup_edge", n, 11);
      nt = 0;
      for (int j = 1; j <= 2560; j++) begin
         @(negedge clk);
         if (j <= 4) chk("half_rate", int'(tick[0]), (j % 2 == 0) ? 1 : 0);
         nt += int'(tick[1]);
      end
      chk("frac_ticks", nt, 30);

      locked_in = 1'b0;
      wait_fall(n);
      chk("fall_edge", n, 3);
      repeat (3) @(negedge clk);
      locked_in = 1'b1;
      repeat (5) @(negedge clk);
      locked_in = 1'b0;
      repeat (3) @(negedge clk);
      locked_in = 1'b1;
      wait_rel(n);
      chk("glitch_restart", n, 11);

      ch_en = 3'b001;
      n = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (tick[0] === 1'b1) begin
            n = k;
            break;
         end
      end
      chk("ovf_found", int'(n >= 0), 1);
      @(negedge clk);
      wr(0, 128);
      chk("wr_ovf_0", int'(tick[0]), 0);
      @(negedge clk);
      chk("wr_ovf_1", int'(tick[0]), 0);
      @(negedge clk);
      chk("wr_ovf_2", int'(tick[0]), 1);
      ch_en = 3'b111;
      wr(3, 0);
      repeat (8) @(negedge clk);

      for (int j = 0; j < 3000; j++) begin
         ch_en = NCH'($urandom);
         inc_we = ($urandom_range(0, 7) == 0);
         inc_sel = 2'($urandom_range(0, 3));
         r = $urandom_range(0, 3);
         inc_wdata = (r == 0) ? AW'(0) : (r == 1) ? AW'(255) :
                     AW'($urandom);
         if ($urandom_range(0, 199) == 0) locked_in = ~locked_in;
         else if (!locked_in && $urandom_range(0, 3) == 0) locked_in = 1'b1;
         @(negedge clk);
      end
      inc_we = 1'b0;
      locked_in = 1'b1;
      ch_en = 3'b111;
      wait_rel(n);
      repeat (5) @(negedge clk);

      #2 rst_n = 1'b0;
      #1;
      chk("async_sys", int'(sys_rst_n), 0);
      chk("async_ok", int'(clk_ok), 0);
      chk("async_tick", int'(tick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_rel(n);
      chk("post_rst_edge", n, 11);

      for (int e = 0; e < 3; e++) loss_event(1'b1);
`ifdef CLKEN_LOSS_CNT_EN
      chk("loss_3", int'(loss_cnt), 3);
      for (int e = 3; e < 300; e++) loss_event(1'b0);
      chk("loss_sat", int'(loss_cnt), 255);
`endif
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
